sprite_fetch_sequencer: RTL and testbench

- Sequences one sprite tile-row fetch per accepted request: generates the VRAM address, reads the low then the high bitplane byte, and strobes them into the sprite pixel shifter's plane latches.
- Drives the shifter's flip select and per-pixel load enables.
- Loads only pixel slots that are currently transparent, so earlier (higher-priority) sprites win on overlap.
- Sits between the sprite X-match logic, VRAM arbiter and sprite pixel shifter; stalls the BG fetcher while busy.

---
 rtl/sprite_fetch_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_sequencer.sv
// Sprite tile-row fetch sequencer: queues X-match requests, reads low/high bitplanes and drives shifter loads.
// Optional abort input when SPR_FETCH_ABORT_EN is defined.
module sprite_fetch_sequencer #(
  parameter int RD_CYCLES = 2,
  parameter int MAX_PEND  = 3
) (
  input  logic        clk,
  input  logic        nreset,
`ifdef SPR_FETCH_ABORT_EN
  input  logic        abort,
`endif
  input  logic        spr_req,
  output logic        spr_ack,
  input  logic [7:0]  spr_tile,
  input  logic [3:0]  spr_row,
  input  logic        spr_xflip,
  input  logic        spr_yflip,
  input  logic        tall,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  input  logic [7:0]  md,
  output logic        lat_lo,
  output logic        lat_hi,
  output logic        xflip,
  input  logic [7:0]  spr_pix_a,
  input  logic [7:0]  spr_pix_b,
  output logic [7:0]  load_en,
  output logic        bg_stall,
  output logic        busy
);
  localparam int DEPTH = MAX_PEND + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0] LAST_CYC = 3'(RD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_LO = 2'd1;
  localparam logic [1:0] S_RD_HI = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  typedef struct packed {
    logic [7:0] tile;
    logic [3:0] row;
    logic       xflip;
    logic       yflip;
    logic       tall;
  } req_t;

  req_t             fifo_mem [DEPTH];
  req_t             head;
  req_t             wr_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   occupancy;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cyc_q, cyc_d;
  logic [10:0]      base_q, base_d;
  logic             wxflip_q, wxflip_d;
  logic             ack_q;
  logic             abort_w;
  logic             push;
  logic             pop;
  logic             q_nonempty;
  logic             cyc_last;
  logic             rd_lo;
  logic             rd_hi;
  logic [3:0]       r_eff;
  logic [7:0]       tile_eff;
  logic             md_unused;

`ifdef SPR_FETCH_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // md only matters to the shifter; the read timing here is fixed by RD_CYCLES.
  assign md_unused = ^md;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q_nonempty = (count_q != '0);
  assign cyc_last   = (cyc_q == LAST_CYC);
  assign head       = fifo_mem[rd_ptr_q];
  assign wr_entry   = '{tile: spr_tile, row: spr_row, xflip: spr_xflip,
                        yflip: spr_yflip, tall: tall};

  // The active fetch counts against capacity, so at most MAX_PEND wait behind it.
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(state_q != S_IDLE);
  assign push      = spr_req & ~abort_w & (occupancy < (CNT_W + 1)'(DEPTH));

  always_comb begin
    r_eff    = head.row;
    tile_eff = head.tile;
    if (head.yflip) begin
      r_eff = head.tall ? (4'd15 - head.row) : {1'b0, 3'd7 - head.row[2:0]};
    end
    if (head.tall) begin
      tile_eff = {head.tile[7:1], r_eff[3]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    pop      = 1'b0;
    base_d   = base_q;
    wxflip_d = wxflip_q;
    case (state_q)
      S_IDLE: begin
        if (q_nonempty) begin
          pop     = 1'b1;
          state_d = S_RD_LO;
          cyc_d   = '0;
        end
      end
      S_RD_LO: begin
        if (cyc_last) begin
          state_d = S_RD_HI;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      S_RD_HI: begin
        if (cyc_last) begin
          state_d = S_LOAD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      default: begin
        cyc_d = '0;
        if (q_nonempty) begin
          pop     = 1'b1;
          state_d = S_RD_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (abort_w) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      pop     = 1'b0;
    end
    if (pop) begin
      base_d   = {tile_eff, r_eff[2:0]};
      wxflip_d = head.xflip;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (abort_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      base_q   <= '0;
      wxflip_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      base_q   <= base_d;
      wxflip_q <= wxflip_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= push;
    end
  end

  assign rd_lo     = (state_q == S_RD_LO);
  assign rd_hi     = (state_q == S_RD_HI);
  assign spr_ack   = ack_q;
  assign vram_rd   = rd_lo | rd_hi;
  assign vram_addr = vram_rd ? {1'b0, base_q, rd_hi} : '0;
  assign lat_lo    = ~(rd_lo & cyc_last);
  assign lat_hi    = ~(rd_hi & cyc_last);
  // Only transparent slots (both planes clear) may be overwritten.
  assign load_en   = (state_q == S_LOAD) ? ~(spr_pix_a | spr_pix_b) : '0;
  assign xflip     = (state_q != S_IDLE) ? wxflip_q : (q_nonempty & head.xflip);
  assign busy      = (state_q != S_IDLE) | q_nonempty;
  assign bg_stall  = busy;

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Directed bench for sprite_fetch_sequencer: vector table of single fetches plus queue, reset and abort sequences.
module tb_sprite_fetch_sequencer;
  localparam int RD_CYCLES = 2;
  localparam int MAX_PEND  = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        spr_req = 1'b0;
  logic        spr_ack;
  logic [7:0]  spr_tile = '0;
  logic [3:0]  spr_row = '0;
  logic        spr_xflip = 1'b0;
  logic        spr_yflip = 1'b0;
  logic        tall = 1'b0;
  logic        vram_rd;
  logic [12:0] vram_addr;
  logic [7:0]  md = '0;
  logic        lat_lo;
  logic        lat_hi;
  logic        xflip;
  logic [7:0]  spr_pix_a = '0;
  logic [7:0]  spr_pix_b = '0;
  logic [7:0]  load_en;
  logic        bg_stall;
  logic        busy;
`ifdef SPR_FETCH_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_fetch_sequencer #(.RD_CYCLES(RD_CYCLES), .MAX_PEND(MAX_PEND)) dut (
    .clk       (clk),
    .nreset    (nreset),
`ifdef SPR_FETCH_ABORT_EN
    .abort     (abort),
`endif
    .spr_req   (spr_req),
    .spr_ack   (spr_ack),
    .spr_tile  (spr_tile),
    .spr_row   (spr_row),
    .spr_xflip (spr_xflip),
    .spr_yflip (spr_yflip),
    .tall      (tall),
    .vram_rd   (vram_rd),
    .vram_addr (vram_addr),
    .md        (md),
    .lat_lo    (lat_lo),
    .lat_hi    (lat_hi),
    .xflip     (xflip),
    .spr_pix_a (spr_pix_a),
    .spr_pix_b (spr_pix_b),
    .load_en   (load_en),
    .bg_stall  (bg_stall),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0]  tile;
    logic [3:0]  row;
    logic        xf;
    logic        yf;
    logic        tl;
    logic [7:0]  pa;
    logic [7:0]  pb;
    logic [12:0] addr;
    logic [7:0]  len;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"}, 32'(vram_rd), 32'd0);
    chk({tag, "_addr"}, 32'(vram_addr), 32'd0);
    chk({tag, "_latlo"}, 32'(lat_lo), 32'd1);
    chk({tag, "_lathi"}, 32'(lat_hi), 32'd1);
    chk({tag, "_xflip"}, 32'(xflip), 32'd0);
    chk({tag, "_load_en"}, 32'(load_en), 32'd0);
    chk({tag, "_bg_stall"}, 32'(bg_stall), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Starts at a negedge with the sequencer idle; ends at the negedge after LOAD.
  task automatic run_fetch(input vec_t v, input int idx);
    spr_req = 1'b1; spr_tile = v.tile; spr_row = v.row;
    spr_xflip = v.xf; spr_yflip = v.yf; tall = v.tl;
    spr_pix_a = v.pa; spr_pix_b = v.pb;
    @(negedge clk);
    spr_req = 1'b0;
    chk("pop_ack", 32'(spr_ack), 32'd1);
    chk("pop_bg_stall", 32'(bg_stall), 32'd1);
    chk("pop_xflip", 32'(xflip), 32'(v.xf));
    chk("pop_rd", 32'(vram_rd), 32'd0);
    for (int c = 0; c < RD_CYCLES; c++) begin
      @(negedge clk);
      chk("lo_rd", 32'(vram_rd), 32'd1);
      chk("lo_addr", 32'(vram_addr), 32'(v.addr));
      chk("lo_latlo", 32'(lat_lo), (c == RD_CYCLES - 1) ? 32'd0 : 32'd1);
      chk("lo_lathi", 32'(lat_hi), 32'd1);
      chk("lo_xflip", 32'(xflip), 32'(v.xf));
    end
    for (int c = 0; c < RD_CYCLES; c++) begin
      @(negedge clk);
      chk("hi_rd", 32'(vram_rd), 32'd1);
      chk("hi_addr", 32'(vram_addr), 32'(v.addr) | 32'd1);
      chk("hi_lathi", 32'(lat_hi), (c == RD_CYCLES - 1) ? 32'd0 : 32'd1);
      chk("hi_latlo", 32'(lat_lo), 32'd1);
      chk("hi_bg_stall", 32'(bg_stall), 32'd1);
    end
    @(negedge clk);
    chk("load_en", 32'(load_en), 32'(v.len));
    chk("load_rd", 32'(vram_rd), 32'd0);
    chk("load_bg_stall", 32'(bg_stall), 32'd1);
    chk("load_xflip", 32'(xflip), 32'(v.xf));
    @(negedge clk);
    chk_idle("post");
    $display("txn %0d: tile=%02h row=%0d xf=%0b yf=%0b tall=%0b addr=%03h load_en=%02h",
             idx, v.tile, v.row, v.xf, v.yf, v.tl, v.addr, v.len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            tile   row   xf    yf    tall  pa     pb     addr      load_en
    vecs[0] = '{8'h42, 4'd5,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 13'h042A, 8'hFF};
    vecs[1] = '{8'h43, 4'd2,  1'b0, 1'b1, 1'b1, 8'h0F, 8'h30, 13'h043A, 8'hC0};
    vecs[2] = '{8'h10, 4'd3,  1'b1, 1'b0, 1'b0, 8'h81, 8'h18, 13'h0106, 8'h66};
    vecs[3] = '{8'h7F, 4'd9,  1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 13'h07FC, 8'h00};
    vecs[4] = '{8'hA4, 4'd11, 1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 13'h0A56, 8'h55};
    vecs[5] = '{8'hFE, 4'd0,  1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 13'h0FFE, 8'hFE};
    vecs[6] = '{8'h33, 4'd15, 1'b0, 1'b1, 1'b1, 8'h00, 8'h80, 13'h0320, 8'h7F};

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(spr_ack), 32'd0);
    chk_idle("rst");
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_fetch(vecs[i], i);
    end

    // Five back-to-back requests: four accepted, fetches chained without bubbles.
    spr_pix_a = 8'h00; spr_pix_b = 8'h00;
    spr_xflip = 1'b0; spr_yflip = 1'b0; tall = 1'b0; spr_row = 4'd0;
    for (int i = 0; i < 5; i++) begin
      spr_req = 1'b1; spr_tile = 8'(i + 1);
      @(negedge clk);
      chk("q_ack", 32'(spr_ack), (i < 4) ? 32'd1 : 32'd0);
    end
    spr_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("q_load_en", 32'(load_en), 32'hFF);
      chk("q_load_busy", 32'(busy), 32'd1);
      @(negedge clk);
      if (k < 3) begin
        chk("q_b2b_rd", 32'(vram_rd), 32'd1);
        chk("q_b2b_addr", 32'(vram_addr), 32'((k + 2) << 4));
        chk("q_b2b_bg_stall", 32'(bg_stall), 32'd1);
        repeat (4) @(negedge clk);
      end else begin
        chk("q_end_busy", 32'(busy), 32'd0);
        chk("q_end_bg_stall", 32'(bg_stall), 32'd0);
      end
      $display("txn queue fetch %0d: tile=%02h done", k, k + 1);
    end

    // Reset pulse in the middle of the high-plane read.
    spr_req = 1'b1; spr_tile = 8'h55; spr_row = 4'd1;
    @(negedge clk);
    spr_req = 1'b0;
    repeat (RD_CYCLES + 1) @(negedge clk);
    chk("mid_hi_addr", 32'(vram_addr), 32'h553);
    nreset = 1'b0;
    #1;
    chk("arst_ack", 32'(spr_ack), 32'd0);
    chk_idle("arst");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk_idle("arst_rel");
    $display("txn reset during RD_HI");
    run_fetch(vecs[0], 100);

`ifdef SPR_FETCH_ABORT_EN
    spr_req = 1'b1; spr_tile = 8'h21; spr_row = 4'd0; spr_xflip = 1'b0;
    @(negedge clk);
    spr_tile = 8'h22;
    @(negedge clk);
    spr_req = 1'b0;
    chk("ab_rd_lo", 32'(vram_rd), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 2 * RD_CYCLES + 4; c++) begin
      chk("ab_no_load", 32'(load_en), 32'd0);
      chk("ab_no_rd", 32'(vram_rd), 32'd0);
      chk("ab_no_stall", 32'(bg_stall), 32'd0);
      @(negedge clk);
    end
    $display("txn abort during RD_LO");
    run_fetch(vecs[1], 200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
